// File: rtl/ddr3_cmd_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ddr3_cmd_timer_pkg
//  Description : Shared DDR3 command encodings ({ras_n,cas_n,we_n}) and
//                default JEDEC timing values, in clock cycles, for the
//                command timer and its refresh sub-block.
//  Revision    : 1.0 - initial release
// ============================================================================
package ddr3_cmd_timer_pkg;

    localparam logic [2:0] CMD_MODE = 3'b000;
    localparam logic [2:0] CMD_REFR = 3'b001;
    localparam logic [2:0] CMD_PREC = 3'b010;
    localparam logic [2:0] CMD_ACTV = 3'b011;
    localparam logic [2:0] CMD_WRIT = 3'b100;
    localparam logic [2:0] CMD_READ = 3'b101;
    localparam logic [2:0] CMD_ZQCL = 3'b110;
    localparam logic [2:0] CMD_NOOP = 3'b111;

    localparam int DEF_T_RCD  = 2;
    localparam int DEF_T_RP   = 2;
    localparam int DEF_T_RFC  = 12;
    localparam int DEF_T_MOD  = 12;
    localparam int DEF_T_ZQ   = 512;
    localparam int DEF_T_CCD  = 4;
    localparam int DEF_T_RDAP = 6;
    localparam int DEF_T_WRAP = 12;
    localparam int DEF_T_RTW  = 6;
    localparam int DEF_T_WTR  = 8;
    localparam int DEF_T_REFI = 780;

    // Column commands carry the auto-precharge flag on address bit 10.
    function automatic logic is_col_cmd(input logic [2:0] cmd);
        return (cmd == CMD_READ) || (cmd == CMD_WRIT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr3_ref_timer.sv
`default_nettype none
// ============================================================================
//  Module      : ddr3_ref_timer
//  Description : tREFI interval counter with refresh-pending bookkeeping.
//                Build option DDR3_REF_POSTPONE_EN turns the single pending
//                flag into a 0..8 counter so refreshes can be postponed while
//                traffic is flowing.
//  Ports       : clock, reset_n     - clock / async active-low reset
//                ref_en             - timer enable (clears timer+pending low)
//                refr_accept        - a REFRESH was accepted this cycle
//                burst_open         - a seq burst is in progress
//                idle               - request line has been quiet 4 cycles
//                ref_req            - refresh wanted
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr3_ref_timer
    import ddr3_cmd_timer_pkg::*;
#(
    parameter int T_REFI = DEF_T_REFI
) (
    input  logic clock,
    input  logic reset_n,
    input  logic ref_en,
    input  logic refr_accept,
    input  logic burst_open,
    input  logic idle,
    output logic ref_req
);

    logic [11:0] tmr_q, tmr_d;
    logic        expire;

    always_comb begin
        expire = ref_en && (tmr_q == 12'(T_REFI - 1));
        tmr_d  = 12'd0;
        if (ref_en && !expire) begin
            tmr_d = tmr_q + 12'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmr_q <= 12'd0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

`ifdef DDR3_REF_POSTPONE_EN
    logic [3:0] pend_q, pend_d;

    // Expiry and accept in the same cycle cancel; the count saturates at 8.
    always_comb begin
        pend_d = pend_q;
        if (!ref_en) begin
            pend_d = 4'd0;
        end else if (expire && !refr_accept) begin
            pend_d = (pend_q == 4'd8) ? 4'd8 : pend_q + 4'd1;
        end else if (!expire && refr_accept && (pend_q != 4'd0)) begin
            pend_d = pend_q - 4'd1;
        end
    end

    assign ref_req = !burst_open &&
                     ((pend_q == 4'd8) || ((pend_q != 4'd0) && idle));
`else
    logic pend_q, pend_d;
    logic unused_idle;

    // Expiry wins over a simultaneous accept, so the new interval is kept.
    always_comb begin
        pend_d = pend_q;
        if (!ref_en) begin
            pend_d = 1'b0;
        end else if (expire) begin
            pend_d = 1'b1;
        end else if (refr_accept) begin
            pend_d = 1'b0;
        end
    end

    assign unused_idle = idle;
    assign ref_req     = pend_q && !burst_open;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ddr3_cmd_timer.sv
`default_nettype none
// ============================================================================
//  Module      : ddr3_cmd_timer
//  Description : Accepts one DDR3 command per req/rdy handshake, registers it
//                onto the DFI command bus for one cycle and then withholds
//                ddl_rdy_o for the gap that command needs (including RD<->WR
//                turnaround). Owns the refresh timer via ddr3_ref_timer.
//                Build option: DDR3_REF_POSTPONE_EN (postponed refresh).
//  Ports       : clock, reset_n            - clock / async active-low reset
//                ref_en_i                  - enable refresh timer
//                ddl_req_i/ddl_rdy_o       - command handshake
//                ddl_seq_i                 - more commands of this burst follow
//                ddl_cmd_i/ba_i/adr_i      - command, bank, address
//                ddl_ref_o                 - refresh request
//                dfi_cs_no/cmd_o/ba_o/adr_o - DFI command bus
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr3_cmd_timer
    import ddr3_cmd_timer_pkg::*;
#(
    parameter int DDR_ROW_BITS = 13,
    parameter int T_RCD  = DEF_T_RCD,
    parameter int T_RP   = DEF_T_RP,
    parameter int T_RFC  = DEF_T_RFC,
    parameter int T_MOD  = DEF_T_MOD,
    parameter int T_ZQ   = DEF_T_ZQ,
    parameter int T_CCD  = DEF_T_CCD,
    parameter int T_RDAP = DEF_T_RDAP,
    parameter int T_WRAP = DEF_T_WRAP,
    parameter int T_RTW  = DEF_T_RTW,
    parameter int T_WTR  = DEF_T_WTR,
    parameter int T_REFI = DEF_T_REFI
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    ref_en_i,
    input  logic                    ddl_req_i,
    input  logic                    ddl_seq_i,
    output logic                    ddl_rdy_o,
    output logic                    ddl_ref_o,
    input  logic [2:0]              ddl_cmd_i,
    input  logic [2:0]              ddl_ba_i,
    input  logic [DDR_ROW_BITS-1:0] ddl_adr_i,
    output logic                    dfi_cs_no,
    output logic [2:0]              dfi_cmd_o,
    output logic [2:0]              dfi_ba_o,
    output logic [DDR_ROW_BITS-1:0] dfi_adr_o
);

    logic [9:0]              wait_q, wait_d;
    logic [3:0]              rtw_q, rtw_d;
    logic [3:0]              wtr_q, wtr_d;
    logic                    rdy_en_q, rdy_en_d;
    logic                    burst_q, burst_d;
    logic                    refr_busy_q, refr_busy_d;
    logic [2:0]              idle_cnt_q, idle_cnt_d;
    logic                    cs_n_q, cs_n_d;
    logic [2:0]              cmd_q, cmd_d;
    logic [2:0]              ba_q, ba_d;
    logic [DDR_ROW_BITS-1:0] adr_q, adr_d;

    logic       accept;
    logic [9:0] gap_m1;
    logic       ref_req;
    logic       idle;
    logic       refr_hold;

    // rdy_en_q keeps the handshake closed during the cycle reset is released.
    assign ddl_rdy_o = rdy_en_q && (wait_q == 10'd0)
                       && !((ddl_cmd_i == CMD_WRIT) && (rtw_q != 4'd0))
                       && !((ddl_cmd_i == CMD_READ) && (wtr_q != 4'd0));
    assign accept    = ddl_req_i && ddl_rdy_o;

    // Gap minus one, because the accept cycle itself counts toward the gap.
    always_comb begin
        gap_m1 = 10'd0;
        case (ddl_cmd_i)
            CMD_ACTV: gap_m1 = 10'(T_RCD - 1);
            CMD_PREC: gap_m1 = 10'(T_RP - 1);
            CMD_REFR: gap_m1 = 10'(T_RFC - 1);
            CMD_MODE: gap_m1 = 10'(T_MOD - 1);
            CMD_ZQCL: gap_m1 = 10'(T_ZQ - 1);
            CMD_READ: gap_m1 = ddl_adr_i[10] ? 10'(T_RDAP - 1) : 10'(T_CCD - 1);
            CMD_WRIT: gap_m1 = ddl_adr_i[10] ? 10'(T_WRAP - 1) : 10'(T_CCD - 1);
            default:  gap_m1 = 10'd0;
        endcase
    end

    always_comb begin
        wait_d      = (wait_q != 10'd0) ? wait_q - 10'd1 : 10'd0;
        rtw_d       = (rtw_q != 4'd0) ? rtw_q - 4'd1 : 4'd0;
        wtr_d       = (wtr_q != 4'd0) ? wtr_q - 4'd1 : 4'd0;
        rdy_en_d    = 1'b1;
        burst_d     = burst_q;
        // The refresh hold ends on the last gap cycle.
        refr_busy_d = refr_busy_q && (wait_q != 10'd1);
        idle_cnt_d  = ddl_req_i ? 3'd0 :
                      ((idle_cnt_q == 3'd4) ? 3'd4 : idle_cnt_q + 3'd1);
        cs_n_d      = 1'b1;
        cmd_d       = CMD_NOOP;
        ba_d        = ba_q;
        adr_d       = adr_q;

        if (accept) begin
            wait_d  = gap_m1;
            burst_d = ddl_seq_i;
            if (ddl_cmd_i != CMD_NOOP) begin
                cs_n_d = 1'b0;
                cmd_d  = ddl_cmd_i;
                ba_d   = ddl_ba_i;
                adr_d  = ddl_adr_i;
            end
            if (is_col_cmd(ddl_cmd_i)) begin
                if (ddl_cmd_i == CMD_READ) begin
                    rtw_d = 4'(T_RTW - 1);
                end else begin
                    wtr_d = 4'(T_WTR - 1);
                end
            end
            if (ddl_cmd_i == CMD_REFR) begin
                refr_busy_d = (T_RFC > 1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_q      <= 10'd0;
            rtw_q       <= 4'd0;
            wtr_q       <= 4'd0;
            rdy_en_q    <= 1'b0;
            burst_q     <= 1'b0;
            refr_busy_q <= 1'b0;
            idle_cnt_q  <= 3'd0;
            cs_n_q      <= 1'b1;
            cmd_q       <= CMD_NOOP;
            ba_q        <= 3'd0;
            adr_q       <= '0;
        end else begin
            wait_q      <= wait_d;
            rtw_q       <= rtw_d;
            wtr_q       <= wtr_d;
            rdy_en_q    <= rdy_en_d;
            burst_q     <= burst_d;
            refr_busy_q <= refr_busy_d;
            idle_cnt_q  <= idle_cnt_d;
            cs_n_q      <= cs_n_d;
            cmd_q       <= cmd_d;
            ba_q        <= ba_d;
            adr_q       <= adr_d;
        end
    end

    assign idle      = (idle_cnt_q == 3'd4);
    assign refr_hold = refr_busy_q && (wait_q != 10'd1);

    ddr3_ref_timer #(
        .T_REFI (T_REFI)
    ) u_ref_timer (
        .clock       (clock),
        .reset_n     (reset_n),
        .ref_en      (ref_en_i),
        .refr_accept (accept && (ddl_cmd_i == CMD_REFR)),
        .burst_open  (burst_q),
        .idle        (idle),
        .ref_req     (ref_req)
    );

    assign ddl_ref_o = ref_req || refr_hold;
    assign dfi_cs_no = cs_n_q;
    assign dfi_cmd_o = cmd_q;
    assign dfi_ba_o  = ba_q;
    assign dfi_adr_o = adr_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_cmd_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr3_cmd_timer
//  Description : Directed self-checking bench for ddr3_cmd_timer (default
//                build, refresh postponement disabled).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr3_cmd_timer;

    localparam logic [2:0] C_MODE = 3'b000;
    localparam logic [2:0] C_REFR = 3'b001;
    localparam logic [2:0] C_PREC = 3'b010;
    localparam logic [2:0] C_ACTV = 3'b011;
    localparam logic [2:0] C_WRIT = 3'b100;
    localparam logic [2:0] C_READ = 3'b101;
    localparam logic [2:0] C_ZQCL = 3'b110;
    localparam logic [2:0] C_NOOP = 3'b111;

    logic        clock;
    logic        reset_n;
    logic        ref_en_i;
    logic        ddl_req_i;
    logic        ddl_seq_i;
    logic        ddl_rdy_o;
    logic        ddl_ref_o;
    logic [2:0]  ddl_cmd_i;
    logic [2:0]  ddl_ba_i;
    logic [12:0] ddl_adr_i;
    logic        dfi_cs_no;
    logic [2:0]  dfi_cmd_o;
    logic [2:0]  dfi_ba_o;
    logic [12:0] dfi_adr_o;

    int checks = 0;
    int errors = 0;

    ddr3_cmd_timer dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .ref_en_i  (ref_en_i),
        .ddl_req_i (ddl_req_i),
        .ddl_seq_i (ddl_seq_i),
        .ddl_rdy_o (ddl_rdy_o),
        .ddl_ref_o (ddl_ref_o),
        .ddl_cmd_i (ddl_cmd_i),
        .ddl_ba_i  (ddl_ba_i),
        .ddl_adr_i (ddl_adr_i),
        .dfi_cs_no (dfi_cs_no),
        .dfi_cmd_o (dfi_cmd_o),
        .dfi_ba_o  (dfi_ba_o),
        .dfi_adr_o (dfi_adr_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Called just after a falling edge. Holds the request until rdy, lets the
    // next rising edge accept it, returns 1 ns after that edge. waits = number
    // of cycles the request saw rdy low.
    task automatic issue(input logic [2:0] cmd, input logic [2:0] ba,
                         input logic [12:0] adr, input logic seq, output int waits);
        ddl_req_i = 1'b1;
        ddl_cmd_i = cmd;
        ddl_ba_i  = ba;
        ddl_adr_i = adr;
        ddl_seq_i = seq;
        waits     = 0;
        #1;
        while (ddl_rdy_o !== 1'b1 && waits < 1000) begin
            @(negedge clock);
            #1;
            waits++;
        end
        if (waits >= 1000) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: cmd %b still not accepted after %0d cycles (required accept)", cmd, waits);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        @(negedge clock);
        ddl_req_i = 1'b0;
        ddl_seq_i = 1'b0;
        repeat (n - 1) @(negedge clock);
    endtask

    task automatic test_reset;
        reset_n   = 1'b0;
        ref_en_i  = 1'b0;
        ddl_req_i = 1'b0;
        ddl_seq_i = 1'b0;
        ddl_cmd_i = C_MODE;
        ddl_ba_i  = 3'd0;
        ddl_adr_i = 13'd0;
        repeat (3) @(negedge clock);
        checks++;
        if ({ddl_rdy_o, ddl_ref_o} !== 2'b00) begin
            errors++;
            $display("FAIL reset_handshake: rdy/ref=%b required 00", {ddl_rdy_o, ddl_ref_o});
        end
        checks++;
        if ({dfi_cs_no, dfi_cmd_o, dfi_ba_o, dfi_adr_o} !== {1'b1, C_NOOP, 3'd0, 13'd0}) begin
            errors++;
            $display("FAIL reset_dfi: cs/cmd/ba/adr=%b/%b/%0h/%0h required 1/111/0/0",
                     dfi_cs_no, dfi_cmd_o, dfi_ba_o, dfi_adr_o);
        end
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (ddl_rdy_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_rdy: rdy=%b required 1", ddl_rdy_o);
        end
    endtask

    task automatic test_actv_read;
        int w;
        idle_cycles(2);
        issue(C_ACTV, 3'd3, 13'h1a5, 1'b0, w);
        checks++;
        if ({dfi_cs_no, dfi_cmd_o, dfi_ba_o, dfi_adr_o} !== {1'b0, C_ACTV, 3'd3, 13'h1a5}) begin
            errors++;
            $display("FAIL actv_dfi: cs/cmd/ba/adr=%b/%b/%0h/%0h required 0/011/3/1a5",
                     dfi_cs_no, dfi_cmd_o, dfi_ba_o, dfi_adr_o);
        end
        @(negedge clock);
        issue(C_READ, 3'd3, 13'h010, 1'b0, w);
        checks++;
        if (w !== 1) begin
            errors++;
            $display("FAIL actv_to_read_wait: %0d cycles required 1", w);
        end
        checks++;
        if ({dfi_cs_no, dfi_cmd_o, dfi_ba_o, dfi_adr_o} !== {1'b0, C_READ, 3'd3, 13'h010}) begin
            errors++;
            $display("FAIL read_dfi: cs/cmd/ba/adr=%b/%b/%0h/%0h required 0/101/3/10",
                     dfi_cs_no, dfi_cmd_o, dfi_ba_o, dfi_adr_o);
        end
        @(negedge clock);
        ddl_req_i = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if ({dfi_cs_no, dfi_cmd_o, dfi_ba_o, dfi_adr_o} !== {1'b1, C_NOOP, 3'd3, 13'h010}) begin
            errors++;
            $display("FAIL dfi_one_cycle: cs/cmd/ba/adr=%b/%b/%0h/%0h required 1/111/3/10 (ba/adr held)",
                     dfi_cs_no, dfi_cmd_o, dfi_ba_o, dfi_adr_o);
        end
    endtask

    task automatic test_turnaround;
        int w;
        idle_cycles(10);
        issue(C_READ, 3'd0, 13'h000, 1'b0, w);
        @(negedge clock);
        issue(C_WRIT, 3'd0, 13'h020, 1'b0, w);
        checks++;
        if (w !== 5) begin
            errors++;
            $display("FAIL read_to_write_wait: %0d cycles required 5", w);
        end
        @(negedge clock);
        issue(C_READ, 3'd0, 13'h030, 1'b0, w);
        checks++;
        if (w !== 7) begin
            errors++;
            $display("FAIL write_to_read_wait: %0d cycles required 7", w);
        end
        @(negedge clock);
        issue(C_READ, 3'd0, 13'h040, 1'b0, w);
        checks++;
        if (w !== 3) begin
            errors++;
            $display("FAIL read_to_read_wait: %0d cycles required 3", w);
        end
    endtask

    task automatic test_autoprecharge;
        int w;
        idle_cycles(10);
        issue(C_READ, 3'd1, 13'h400, 1'b0, w);
        @(negedge clock);
        issue(C_ACTV, 3'd1, 13'h0ff, 1'b0, w);
        checks++;
        if (w !== 5) begin
            errors++;
            $display("FAIL rdap_to_actv_wait: %0d cycles required 5", w);
        end
        @(negedge clock);
        issue(C_PREC, 3'd1, 13'h000, 1'b0, w);
        checks++;
        if (w !== 1) begin
            errors++;
            $display("FAIL actv_to_prec_wait: %0d cycles required 1", w);
        end
        @(negedge clock);
        issue(C_ACTV, 3'd2, 13'h055, 1'b0, w);
        checks++;
        if (w !== 1) begin
            errors++;
            $display("FAIL prec_to_actv_wait: %0d cycles required 1", w);
        end
    endtask

    task automatic test_noop;
        int w;
        idle_cycles(10);
        issue(C_NOOP, 3'd7, 13'h1fff, 1'b0, w);
        checks++;
        if ({w[3:0], dfi_cs_no, dfi_cmd_o} !== {4'd0, 1'b1, C_NOOP}) begin
            errors++;
            $display("FAIL noop_not_driven: wait=%0d cs=%b cmd=%b required 0/1/111", w, dfi_cs_no, dfi_cmd_o);
        end
        @(negedge clock);
        issue(C_ACTV, 3'd4, 13'h011, 1'b0, w);
        checks++;
        if ({w[3:0], dfi_cs_no, dfi_cmd_o} !== {4'd0, 1'b0, C_ACTV}) begin
            errors++;
            $display("FAIL noop_gap: wait=%0d cs=%b cmd=%b required 0/0/011", w, dfi_cs_no, dfi_cmd_o);
        end
    endtask

    task automatic test_refresh;
        int n;
        int w;
        int lows;
        int fall;
        idle_cycles(10);
        ref_en_i = 1'b1;
        n = 0;
        while (n < 2000) begin
            @(posedge clock);
            #1;
            n++;
            if (ddl_ref_o === 1'b1) break;
        end
        checks++;
        if (n !== 780) begin
            errors++;
            $display("FAIL refi_interval: ref rose after %0d cycles required 780", n);
        end
        @(negedge clock);
        issue(C_REFR, 3'd0, 13'h000, 1'b0, w);
        checks++;
        if ({w[3:0], ddl_ref_o} !== {4'd0, 1'b1}) begin
            errors++;
            $display("FAIL refr_accept: wait=%0d ref=%b required 0/1", w, ddl_ref_o);
        end
        @(negedge clock);
        ddl_req_i = 1'b0;
        lows = 0;
        fall = -1;
        for (int c = 1; c <= 40; c++) begin
            if (ddl_rdy_o === 1'b1) break;
            lows++;
            if (ddl_ref_o === 1'b0 && fall < 0) fall = c;
            @(negedge clock);
        end
        checks++;
        if (lows !== 11) begin
            errors++;
            $display("FAIL trfc_rdy_low: %0d cycles required 11", lows);
        end
        checks++;
        if (fall !== 11) begin
            errors++;
            $display("FAIL ref_fall_cycle: ref fell in gap cycle %0d required 11", fall);
        end
        ref_en_i = 1'b0;
    endtask

    task automatic test_burst_refresh;
        int w;
        int highs;
        idle_cycles(4);
        ref_en_i = 1'b1;
        issue(C_READ, 3'd2, 13'h008, 1'b1, w);
        @(negedge clock);
        ddl_req_i = 1'b0;
        highs = 0;
        repeat (800) begin
            @(negedge clock);
            if (ddl_ref_o !== 1'b0) highs++;
        end
        checks++;
        if (highs !== 0) begin
            errors++;
            $display("FAIL burst_blocks_ref: ref high %0d cycles required 0", highs);
        end
        issue(C_READ, 3'd2, 13'h010, 1'b1, w);
        checks++;
        if ({w[3:0], ddl_ref_o} !== {4'd0, 1'b0}) begin
            errors++;
            $display("FAIL burst_mid_read: wait=%0d ref=%b required 0/0", w, ddl_ref_o);
        end
        @(negedge clock);
        issue(C_READ, 3'd2, 13'h018, 1'b0, w);
        checks++;
        if ({w[3:0], ddl_ref_o} !== {4'd3, 1'b1}) begin
            errors++;
            $display("FAIL burst_close_ref: wait=%0d ref=%b required 3/1", w, ddl_ref_o);
        end
        @(negedge clock);
        issue(C_REFR, 3'd0, 13'h000, 1'b0, w);
        idle_cycles(15);
        ref_en_i = 1'b0;
        #1;
        checks++;
        if (ddl_ref_o !== 1'b0) begin
            errors++;
            $display("FAIL ref_cleared: ref=%b required 0", ddl_ref_o);
        end
    endtask

    task automatic test_reset_mid_zq;
        int w;
        idle_cycles(4);
        issue(C_ZQCL, 3'd5, 13'h400, 1'b0, w);
        checks++;
        if ({dfi_cs_no, dfi_cmd_o, dfi_ba_o, dfi_adr_o} !== {1'b0, C_ZQCL, 3'd5, 13'h400}) begin
            errors++;
            $display("FAIL zqcl_dfi: cs/cmd/ba/adr=%b/%b/%0h/%0h required 0/110/5/400",
                     dfi_cs_no, dfi_cmd_o, dfi_ba_o, dfi_adr_o);
        end
        idle_cycles(20);
        #1;
        checks++;
        if (ddl_rdy_o !== 1'b0) begin
            errors++;
            $display("FAIL zq_gap_rdy: rdy=%b required 0", ddl_rdy_o);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({ddl_rdy_o, ddl_ref_o, dfi_cs_no, dfi_cmd_o, dfi_ba_o, dfi_adr_o} !==
            {1'b0, 1'b0, 1'b1, C_NOOP, 3'd0, 13'd0}) begin
            errors++;
            $display("FAIL async_reset: rdy/ref/cs/cmd/ba/adr=%b/%b/%b/%b/%0h/%0h required 0/0/1/111/0/0",
                     ddl_rdy_o, ddl_ref_o, dfi_cs_no, dfi_cmd_o, dfi_ba_o, dfi_adr_o);
        end
        @(negedge clock);
        reset_n   = 1'b1;
        ddl_req_i = 1'b1;
        ddl_cmd_i = C_READ;
        @(posedge clock);
        #1;
        checks++;
        if ({ddl_rdy_o, dfi_cs_no} !== 2'b11) begin
            errors++;
            $display("FAIL post_reset_rdy: rdy/cs=%b required 11", {ddl_rdy_o, dfi_cs_no});
        end
        @(negedge clock);
        ddl_req_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_actv_read();
        test_turnaround();
        test_autoprecharge();
        test_noop();
        test_refresh();
        test_burst_refresh();
        test_reset_mid_zq();
        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
